// File: rtl/window3x3_gen.sv
// 3x3 sliding-window generator over a raster pixel stream, with two line buffers,
// end-of-frame flush and selectable zero/replicate border handling.
module window3x3_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int BORDER = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic                in_sof,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [9*DATA_W-1:0] out_win,
  output logic                out_eof,
  output logic                err_sync
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          col_q, col_d, step_col, ccol_q, ccol_d;
  logic [RW-1:0]          row_q, row_d, step_row, crow_q, crow_d;
  logic                   step, restart, emit, eof, err;
  logic [DATA_W-1:0]      step_data;
  logic [DATA_W-1:0]      lb0_mem [IMG_W];
  logic [DATA_W-1:0]      lb1_mem [IMG_W];
  logic [DATA_W-1:0]      lb0_rd_q, lb1_rd_q;
  logic [8:0][DATA_W-1:0] win_q, win_d;
  logic [9*DATA_W-1:0]    masked, out_win_q, out_win_d;
  logic                   out_valid_q, out_eof_q, err_q;
  logic                   row_lo, row_hi, col_lo, col_hi;

  // (col,row) is the raster position of the sample step; (ccol,crow) is the
  // centre of the next window to be emitted, trailing the sample by IMG_W+1.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    ccol_d    = ccol_q;
    crow_d    = crow_q;
    step      = 1'b0;
    restart   = 1'b0;
    emit      = 1'b0;
    eof       = 1'b0;
    err       = 1'b0;
    step_data = in_data;
    step_col  = col_q;
    step_row  = row_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (in_sof) begin
            step    = 1'b1;
            restart = 1'b1;
            state_d = S_RUN;
          end else begin
            err = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (in_valid) begin
          step    = 1'b1;
          restart = in_sof;
          err     = in_sof;
        end
      end
      S_FLUSH: begin
        step      = 1'b1;
        step_data = '0;
      end
      default: state_d = S_IDLE;
    endcase

    if (restart) begin
      step_col = '0;
      step_row = '0;
      ccol_d   = '0;
      crow_d   = '0;
    end

    if (step) begin
      col_d = (step_col == COL_LAST) ? '0 : step_col + 1'b1;
      if (state_q != S_FLUSH && step_col == COL_LAST) begin
        row_d = step_row + 1'b1;
      end else begin
        row_d = step_row;
      end
      // Windows start once sample IMG_W+1 has arrived; every flush step emits.
      emit = (state_q == S_FLUSH) ||
             (!restart && (step_row >= RW'(2) || (step_row == RW'(1) && step_col != '0)));
      if (emit) begin
        eof = (crow_q == ROW_LAST) && (ccol_q == COL_LAST);
        if (ccol_q == COL_LAST) begin
          ccol_d = '0;
          crow_d = crow_q + 1'b1;
        end else begin
          ccol_d = ccol_q + 1'b1;
        end
      end
      if (state_q == S_RUN && !restart && step_row == ROW_LAST && step_col == COL_LAST) begin
        state_d = S_FLUSH;
      end
      if (eof) begin
        state_d = S_IDLE;
        col_d   = '0;
        row_d   = '0;
        ccol_d  = '0;
        crow_d  = '0;
      end
    end
  end

  assign row_lo = (crow_q == '0);
  assign row_hi = (crow_q == ROW_LAST);
  assign col_lo = (ccol_q == '0);
  assign col_hi = (ccol_q == COL_LAST);

  // Raw window shifts left; the new right column is {2 lines ago, 1 line ago, now}.
  // Out-of-image taps are zeroed or remapped onto the centre row/column.
  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    for (genvar gj = 0; gj < 3; gj++) begin : g_col
      logic row_out, col_out;
      if (gj < 2) begin : g_shift
        assign win_d[3*gi+gj] = win_q[3*gi+gj+1];
      end else if (gi == 0) begin : g_lb1
        assign win_d[3*gi+gj] = lb1_rd_q;
      end else if (gi == 1) begin : g_lb0
        assign win_d[3*gi+gj] = lb0_rd_q;
      end else begin : g_new
        assign win_d[3*gi+gj] = step_data;
      end
      assign row_out = (gi == 0) ? row_lo : ((gi == 2) ? row_hi : 1'b0);
      assign col_out = (gj == 0) ? col_lo : ((gj == 2) ? col_hi : 1'b0);
      if (BORDER != 0) begin : g_rep
        assign masked[(3*gi+gj)*DATA_W +: DATA_W] =
          row_out ? (col_out ? win_d[4] : win_d[3+gj])
                  : (col_out ? win_d[3*gi+1] : win_d[3*gi+gj]);
      end else begin : g_zero
        assign masked[(3*gi+gj)*DATA_W +: DATA_W] =
          (row_out || col_out) ? '0 : win_d[3*gi+gj];
      end
    end
  end

  assign out_win_d = emit ? masked : out_win_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      ccol_q      <= '0;
      crow_q      <= '0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
      err_q       <= 1'b0;
      out_win_q   <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      ccol_q      <= ccol_d;
      crow_q      <= crow_d;
      if (step) begin
        win_q <= win_d;
      end
      out_valid_q <= emit;
      out_eof_q   <= eof;
      err_q       <= err;
      out_win_q   <= out_win_d;
    end
  end

  // Cascaded line buffers; the read register prefetches the slot the next step will use.
  always_ff @(posedge clk) begin
    if (step) begin
      lb0_mem[step_col] <= step_data;
      lb1_mem[step_col] <= lb0_rd_q;
    end
    lb0_rd_q <= lb0_mem[col_d];
    lb1_rd_q <= lb1_mem[col_d];
  end

  assign in_ready  = (state_q != S_FLUSH);
  assign out_valid = out_valid_q;
  assign out_win   = out_win_q;
  assign out_eof   = out_eof_q;
  assign err_sync  = err_q;
endmodule

// File: tb/tb_window3x3_gen.sv
// Bench for window3x3_gen: a 4x3 image through a zero-border and a replicate-border instance,
// checked each cycle against a sample-index model and against hand-computed windows.
module tb_window3x3_gen;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready0, in_ready1, out_valid0, out_valid1;
  logic        out_eof0, out_eof1, err0, err1;
  logic [71:0] out_win0, out_win1;

  always #5 clk = ~clk;

  window3x3_gen #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .BORDER(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .in_ready(in_ready0), .out_valid(out_valid0), .out_win(out_win0),
    .out_eof(out_eof0), .err_sync(err0)
  );

  window3x3_gen #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .BORDER(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_win(out_win1),
    .out_eof(out_eof1), .err_sync(err1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_w(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [71:0] pack9(input int a0, input int a1, input int a2,
                                        input int a3, input int a4, input int a5,
                                        input int a6, input int a7, input int a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  // Window for raster centre n, built straight from pixel coordinates.
  int img [H][W];
  function automatic logic [71:0] win_calc(input int n, input int border, input bit from_img);
    logic [71:0] res;
    int r, c, rr, cc, v;
    bit outside;
    res = '0;
    r = n / W;
    c = n % W;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        rr = r - 1 + i;
        cc = c - 1 + j;
        outside = (rr < 0) || (rr >= H) || (cc < 0) || (cc >= W);
        rr = (rr < 0) ? 0 : ((rr >= H) ? H - 1 : rr);
        cc = (cc < 0) ? 0 : ((cc >= W) ? W - 1 : cc);
        v = from_img ? img[rr][cc] : 10 * rr + cc + 1;
        if (outside && border == 0) v = 0;
        res[(3*i+j)*8 +: 8] = 8'(v);
      end
    end
    return res;
  endfunction

  // Model state: mode 0 idle, 1 receiving, 2 flushing; m_k is the sample step index.
  int          m_mode = 0;
  int          m_k = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          acc6_cyc = -1;
  logic        e_valid = 1'b0, e_eof = 1'b0, e_err = 1'b0, e_ready = 1'b1;
  logic [71:0] e_win0 = '0, e_win1 = '0;

  initial begin
    bit step, was_ready;
    int n;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = 0; m_k = 0;
        e_valid = 1'b0; e_eof = 1'b0; e_err = 1'b0; e_ready = 1'b1;
        e_win0 = '0; e_win1 = '0;
      end else begin
        cyc++;
        e_valid = 1'b0; e_eof = 1'b0; e_err = 1'b0;
        step = 1'b0;
        was_ready = (m_mode != 2);
        if (was_ready && in_valid) begin
          acc_cnt++;
          if (acc_cnt == 6 && acc6_cyc < 0) acc6_cyc = cyc;
        end
        if (m_mode == 0) begin
          if (in_valid) begin
            if (in_sof) begin m_k = 0; step = 1'b1; m_mode = 1; end
            else e_err = 1'b1;
          end
        end else if (m_mode == 1) begin
          if (in_valid) begin
            if (in_sof) begin e_err = 1'b1; m_k = 0; end
            step = 1'b1;
          end
        end else begin
          step = 1'b1;
        end
        if (step) begin
          if (m_k < N) img[m_k / W][m_k % W] = int'(in_data);
          if (m_k >= W + 1) begin
            n = m_k - W - 1;
            e_valid = 1'b1;
            e_win0 = win_calc(n, 0, 1'b1);
            e_win1 = win_calc(n, 1, 1'b1);
            if (n == N - 1) begin e_eof = 1'b1; m_mode = 0; end
          end
          if (m_mode == 1 && m_k == N - 1) m_mode = 2;
          m_k++;
        end
        e_ready = (m_mode != 2);
      end
    end
  end

  logic [71:0] cap0 [32];
  logic [71:0] cap1 [32];
  int cnt0 = 0, cnt1 = 0, eof_cnt0 = 0, eof_idx0 = -1;
  int ready_low = 0, err_cnt = 0, first_valid_cyc = -1;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk_b("in_ready_b0", in_ready0, e_ready);
      chk_b("in_ready_b1", in_ready1, e_ready);
      chk_b("out_valid_b0", out_valid0, e_valid);
      chk_b("out_valid_b1", out_valid1, e_valid);
      chk_b("out_eof_b0", out_eof0, e_eof);
      chk_b("out_eof_b1", out_eof1, e_eof);
      chk_b("err_sync_b0", err0, e_err);
      chk_b("err_sync_b1", err1, e_err);
      if (e_valid) begin
        chk_w("win_b0", out_win0, e_win0);
        chk_w("win_b1", out_win1, e_win1);
      end
      if (out_valid0 && cnt0 < 32) begin
        cap0[cnt0] = out_win0;
        if (out_eof0) begin eof_idx0 = cnt0; eof_cnt0++; end
        cnt0++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (out_valid1 && cnt1 < 32) begin
        cap1[cnt1] = out_win1;
        cnt1++;
      end
      if (!in_ready0) ready_low++;
      if (err0) err_cnt++;
    end
  end

  task automatic clr();
    cnt0 = 0; cnt1 = 0; eof_cnt0 = 0; eof_idx0 = -1; ready_low = 0;
    err_cnt = 0; first_valid_cyc = -1; acc_cnt = 0; acc6_cyc = -1;
  endtask

  task automatic send(input logic [7:0] d, input logic sof, input bit gap);
    bit done;
    int t;
    if (gap && $urandom_range(1, 0) == 1) begin
      in_valid = 1'b0;
      repeat ($urandom_range(2, 1)) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1; in_data = d; in_sof = sof;
    done = 1'b0; t = 0;
    while (!done) begin
      done = in_ready0;
      @(posedge clk); #1;
      t++;
      if (!done && t > 50) begin
        n_cmp++; n_bad++;
        $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, expected 1");
        done = 1'b1;
      end
    end
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic send_pixels(input int count, input bit gap);
    for (int k = 0; k < count; k++) begin
      send(8'(10 * (k / W) + (k % W) + 1), k == 0, gap);
    end
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  task automatic chk_frame(input string name, input int base);
    for (int n = 0; n < N; n++) begin
      chk_w({name, "_b0"}, cap0[base + n], win_calc(n, 0, 1'b0));
      chk_w({name, "_b1"}, cap1[base + n], win_calc(n, 1, 1'b0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_b("rst_out_valid", out_valid0, 1'b0);
    chk_w("rst_out_win", out_win0, '0);
    chk_b("rst_in_ready", in_ready0, 1'b1);
    rst_n = 1'b1;
    idle(1);

    chk_w("model_c00_b0", win_calc(0, 0, 1'b0), pack9(0, 0, 0, 0, 1, 2, 0, 11, 12));
    chk_w("model_c23_b1", win_calc(11, 1, 1'b0), pack9(13, 14, 14, 23, 24, 24, 23, 24, 24));

    // Gap-free frame.
    clr();
    send_pixels(N, 1'b0);
    idle(8);
    chk_i("nwin_b0", cnt0, N);
    chk_i("nwin_b1", cnt1, N);
    chk_i("eof_index", eof_idx0, N - 1);
    chk_i("eof_count", eof_cnt0, 1);
    chk_i("ready_low_cycles", ready_low, W + 1);
    chk_i("first_valid_cycle", first_valid_cyc, acc6_cyc);
    chk_w("c00_b0", cap0[0], pack9(0, 0, 0, 0, 1, 2, 0, 11, 12));
    chk_w("c11_b0", cap0[5], pack9(1, 2, 3, 11, 12, 13, 21, 22, 23));
    chk_w("c13_wrap_b0", cap0[7], pack9(3, 4, 0, 13, 14, 0, 23, 24, 0));
    chk_w("c00_b1", cap1[0], pack9(1, 1, 2, 1, 1, 2, 11, 11, 12));
    chk_w("c23_b1", cap1[11], pack9(13, 14, 14, 23, 24, 24, 23, 24, 24));
    chk_frame("frame1", 0);

    // Random input gaps must not change the window sequence.
    clr();
    send_pixels(N, 1'b1);
    idle(8);
    chk_i("gap_nwin_b0", cnt0, N);
    chk_i("gap_nwin_b1", cnt1, N);
    chk_frame("gap", 0);

    // Framing errors: stray pixel in idle, then restart at sample 7.
    clr();
    send(8'd99, 1'b0, 1'b0);
    idle(4);
    chk_i("nosof_nwin", cnt0, 0);
    chk_i("nosof_err", err_cnt, 1);
    send_pixels(7, 1'b0);
    send_pixels(N, 1'b0);
    idle(8);
    chk_i("abort_err", err_cnt, 2);
    chk_i("abort_nwin", cnt0, N + 2);
    chk_i("abort_eof_count", eof_cnt0, 1);
    chk_i("abort_eof_index", eof_idx0, N + 1);
    chk_frame("after_abort", 2);

    // Reset asserted during the flush.
    clr();
    send_pixels(N, 1'b0);
    idle(1);
    chk_b("flush_in_ready", in_ready0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_b("rstflush_valid", out_valid0, 1'b0);
    chk_b("rstflush_eof", out_eof0, 1'b0);
    chk_b("rstflush_err", err0, 1'b0);
    chk_w("rstflush_win_b0", out_win0, '0);
    chk_w("rstflush_win_b1", out_win1, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    clr();
    send_pixels(N, 1'b0);
    idle(8);
    chk_i("post_rst_nwin", cnt0, N);
    chk_i("post_rst_eof_index", eof_idx0, N - 1);
    chk_frame("post_rst", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/window3x3_gen.md
Name: window3x3_gen

Overview:
- Parametrised 3x3 sliding-window generator for raster pixel streams. Successor to the fixed 9-tap shift window.
- Two internal line buffers of IMG_W entries make the window span true image rows.
- Valid/ready input, valid-only output, selectable border mode.
- Automatic end-of-frame flush: exactly one window per image pixel, centred on that pixel.
- Sits between pixel source and 3x3 filter kernels (mean, median, Sobel).

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_W, 640, pixels per line; must be >= 2.
- IMG_H, 480, lines per frame; must be >= 2.
- BORDER, 0, out-of-image tap value: 0 = zero padding, 1 = replicate nearest edge pixel.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input pixel valid
- in_sof  in  1  start of frame; qualifies pixel (0,0), valid only with in_valid
- in_data  in  DATA_W  input pixel, raster order
- in_ready  out  1  block accepts a pixel this cycle
- out_valid  out  1  window valid, single-cycle pulse per window
- out_win  out  9*DATA_W  window; tap(i,j) = out_win[(3*i+j)*DATA_W +: DATA_W] = pixel (r-1+i, c-1+j) for centre (r,c)
- out_eof  out  1  asserted with the last window of a frame
- err_sync  out  1  one-cycle pulse on a framing error

Behaviour:
- Reset: state IDLE; out_valid, out_eof, err_sync = 0; out_win = 0; row/col counters = 0. Line-buffer contents are don't-care and are never emitted unmasked.
- in_ready = 1 in IDLE and RUN, 0 in FLUSH. A pixel is accepted when in_valid & in_ready.
- IDLE:
  - Accepted pixel with in_sof=1: becomes sample 0, go to RUN.
  - Accepted pixel with in_sof=0: dropped, err_sync pulses.
- RUN: each accepted pixel is the next sample index k. After sample IMG_W*IMG_H-1, go to FLUSH.
- FLUSH:
  - Lasts exactly IMG_W+1 cycles; each cycle is an internal sample step carrying no data.
  - Then go to IDLE. A new frame may start in the first IDLE cycle.
- Output timing:
  - The window centred on raster index n = r*IMG_W+c is emitted (out_valid=1) in the cycle after sample step n+IMG_W+1.
  - First window follows sample IMG_W+1. No output for sample steps 0..IMG_W.
  - Input gaps (in_valid=0) produce identical output gaps. No backpressure on the output.
- Borders:
  - Taps with row < 0, row >= IMG_H, col < 0 or col >= IMG_W are replaced per BORDER.
  - The column wrap between lines must never leak pixels from the adjacent line into the window.
- out_eof = 1 together with out_valid for the window at n = IMG_W*IMG_H-1. Exactly IMG_W*IMG_H windows per frame.
- in_sof on an accepted pixel while in RUN:
  - err_sync pulses and the current frame is aborted; no further windows from it, no out_eof.
  - That pixel becomes sample 0 of a new frame.
- in_sof is ignored in FLUSH because in_ready=0.
- Arithmetic: no arithmetic on pixel data; counters are sized as clog2(IMG_W) and clog2(IMG_H+1) bits.
- Reset mid-frame: immediate return to reset values; the partial frame is lost.

Test Plan:
Common setup for all tests: IMG_W=4, IMG_H=3, pixel (r,c) = 10*r+c+1, continuous in_valid.
- BORDER=0, one frame:
  - first out_valid one cycle after the 6th accepted pixel;
  - centre (0,0) -> taps 0,0,0,0,1,2,0,11,12;
  - centre (1,1) -> taps 1,2,3,11,12,13,21,22,23;
  - 12 windows total, out_eof on the 12th;
  - in_ready low for exactly 5 cycles.
- BORDER=1, same frame:
  - centre (0,0) -> taps 1,1,2,1,1,2,11,11,12;
  - centre (2,3) -> taps 13,14,14,23,24,24,23,24,24.
- Line-wrap check, BORDER=0: centre (1,3) -> taps 3,4,0,13,14,0,23,24,0 (no pixel 21 leakage).
- Random in_valid gaps (~50%): out_win sequence matches the gap-free run; out_valid count = 12.
- Framing: a pixel without in_sof in IDLE -> err_sync pulse, no out_valid; in_sof at sample 7 -> err_sync, no out_eof for the aborted frame, the following frame is fully correct.
- Assert rst_n low during FLUSH -> all outputs 0 next edge; after release, a new frame is correct with no stale taps.
